// File: rtl/c2_pkg.sv
// Shared encodings for the bit-serial two's-complement sequencer:
// operation codes and FSM state encodings.
package c2_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } c2_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } c2_state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// 1-bit full adder built from two half-adder (xor/and) pairs and an or.
// The sequencer reuses this single cell for every bit position.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p_s;
  logic g_s;
  logic c2_s;

  assign p_s  = a ^ b;
  assign g_s  = a & b;
  assign sum  = p_s ^ cin;
  assign c2_s = p_s & cin;
  assign cout = g_s | c2_s;

endmodule

// File: rtl/serial_c2_sequencer.sv
// Bit-serial add/subtract/negate/pass unit. One full-adder cell is stepped
// LSB-first over WIDTH cycles; the result is assembled in an internal shift
// register and copied to the result port only when the operation completes.
// Optional feature: define OVF_FLAG_EN to add the signed-overflow output ovf.
module serial_c2_sequencer
  import c2_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef OVF_FLAG_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  c2_state_e        state_r;
  c2_state_e        state_s;
  logic             accept_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             carry_r;
  // Holds the WIDTH-1 low result bits; the final sum bit joins them at completion.
  logic [WIDTH-2:0] acc_r;
  logic [WIDTH-1:0] acc_full_s;
  logic [WIDTH-1:0] x_ld_s;
  logic [WIDTH-1:0] y_ld_s;
  logic             cin_ld_s;
  logic             sum_s;
  logic             carry_s;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
`ifdef OVF_FLAG_EN
  logic             ovf_r;
`endif

  serial_fa_cell u_fa (
    .a    (x_r[0]),
    .b    (y_r[0]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (carry_s)
  );

  // New sum bit on top of the bits collected so far.
  assign acc_full_s = {sum_s, acc_r};

  // Next-state logic: accept only from IDLE/DONE, finish after the last bit.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s  = S_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == LAST_BIT) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          state_s  = S_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Operand preconditioning: subtraction and negation become x + ~y + 1.
  always_comb begin
    x_ld_s   = a;
    y_ld_s   = {WIDTH{1'b0}};
    cin_ld_s = 1'b0;
    case (op)
      OP_ADD: begin
        x_ld_s   = a;
        y_ld_s   = b;
        cin_ld_s = 1'b0;
      end
      OP_SUB: begin
        x_ld_s   = a;
        y_ld_s   = ~b;
        cin_ld_s = 1'b1;
      end
      OP_NEG: begin
        x_ld_s   = {WIDTH{1'b0}};
        y_ld_s   = ~a;
        cin_ld_s = 1'b1;
      end
      OP_PASS: begin
        x_ld_s   = a;
        y_ld_s   = {WIDTH{1'b0}};
        cin_ld_s = 1'b0;
      end
      default: begin
        x_ld_s   = a;
        y_ld_s   = {WIDTH{1'b0}};
        cin_ld_s = 1'b0;
      end
    endcase
  end

  // Datapath, FSM state and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      acc_r    <= {(WIDTH-1){1'b0}};
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == S_IDLE) || (state_s == S_DONE);
      busy_r  <= (state_s == S_RUN);
      done_r  <= (state_s == S_DONE);
      if (accept_s) begin
        x_r     <= x_ld_s;
        y_r     <= y_ld_s;
        carry_r <= cin_ld_s;
        cnt_r   <= {CW{1'b0}};
        acc_r   <= {(WIDTH-1){1'b0}};
      end else if (state_r == S_RUN) begin
        x_r     <= x_r >> 1;
        y_r     <= y_r >> 1;
        carry_r <= carry_s;
        cnt_r   <= cnt_r + CW'(1);
        acc_r   <= acc_full_s[WIDTH-1:1];
        if (cnt_r == LAST_BIT) begin
          result_r <= acc_full_s;
          cout_r   <= carry_s;
`ifdef OVF_FLAG_EN
          // carry_r is the carry into the MSB on the final step.
          ovf_r    <= carry_r ^ carry_s;
`endif
        end
      end
    end
  end

  assign ready  = ready_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
`ifdef OVF_FLAG_EN
  assign ovf    = ovf_r;
`endif

endmodule
